// File: rtl/lu_op_decoder_if.sv
// lu_op_decoder_if: sample stream, result stream and status signals of lu_op_decoder
interface lu_op_decoder_if;
  logic       start, in_valid, in_ready, in_a, in_b, in_s;
  logic       out_valid, out_ready, out_match, busy;
  logic [2:0] out_op;
  logic [3:0] out_tt;
  logic [1:0] out_err;
  modport master (
    output start, in_valid, in_a, in_b, in_s, out_ready,
    input  in_ready, out_valid, out_op, out_tt, out_match, out_err, busy
  );
  modport slave (
    input  start, in_valid, in_a, in_b, in_s, out_ready,
    output in_ready, out_valid, out_op, out_tt, out_match, out_err, busy
  );
endinterface

// File: rtl/lu_op_decoder.sv
// lu_op_decoder: rebuilds the logic-unit truth table from observed samples and decodes its select code.
// Optional macro LU_DEC_CONFLICT_EN: a contradicting repeat sample ends the decode with a conflict error.
module lu_op_decoder #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TW             = 5
) (
  input logic             clk,
  input logic             rst_n,
  lu_op_decoder_if.slave  io_bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, RESULT} state_t;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  state_t        r_state, w_state_nx;
  logic [3:0]    r_seen, r_tt, w_seen_nx, w_tt_nx;
  logic [3:0]    w_mask, w_seen_acc, w_tt_acc, w_ld_tt;
  logic [TW-1:0] r_timer, w_timer_nx;
  logic [2:0]    r_op, w_dec_op;
  logic [3:0]    r_out_tt;
  logic          r_match;
  logic [1:0]    r_err, w_ld_err, w_idx;
  logic          w_acc, w_conf, w_to, w_load;
  assign w_idx      = {io_bus.in_a, io_bus.in_b};
  assign w_mask     = 4'b0001 << w_idx;
  assign w_acc      = (r_state == COLLECT) & io_bus.in_valid & ~io_bus.start;
  assign w_seen_acc = w_acc ? (r_seen | w_mask) : r_seen;
  assign w_tt_acc   = w_acc ? ((r_tt & ~w_mask) | ({4{io_bus.in_s}} & w_mask)) : r_tt;
  assign w_to       = (TIMEOUT_CYCLES != 0) && (r_timer == TO_LAST);
`ifdef LU_DEC_CONFLICT_EN
  assign w_conf = w_acc & r_seen[w_idx] & (r_tt[w_idx] != io_bus.in_s);
`else
  assign w_conf = 1'b0;
`endif
  always_comb begin
    case (w_ld_tt)
      4'b0011: w_dec_op = 3'b000;
      4'b1000: w_dec_op = 3'b001;
      4'b0111: w_dec_op = 3'b010;
      4'b0110: w_dec_op = 3'b011;
      4'b1001: w_dec_op = 3'b100;
      4'b1110: w_dec_op = 3'b101;
      4'b0001: w_dec_op = 3'b110;
      default: w_dec_op = 3'b111;
    endcase
  end
  // Priority inside COLLECT: conflict, then completion, then timeout; start overrides all.
  always_comb begin
    w_state_nx = r_state;
    w_seen_nx  = r_seen;
    w_tt_nx    = r_tt;
    w_timer_nx = r_timer;
    w_load     = 1'b0;
    w_ld_tt    = w_tt_acc;
    w_ld_err   = 2'b00;
    case (r_state)
      IDLE: w_state_nx = IDLE;
      COLLECT: begin
        w_seen_nx  = w_seen_acc;
        w_tt_nx    = w_tt_acc;
        w_timer_nx = r_timer + 1'b1;
        if (w_conf) begin
          w_state_nx = RESULT;
          w_load     = 1'b1;
          w_ld_tt    = r_tt;
          w_ld_err   = 2'b01;
        end else if (w_seen_acc == 4'hF) begin
          w_state_nx = RESULT;
          w_load     = 1'b1;
        end else if (w_to) begin
          w_state_nx = RESULT;
          w_load     = 1'b1;
          w_ld_err   = 2'b10;
        end
      end
      RESULT: w_state_nx = io_bus.out_ready ? IDLE : RESULT;
      default: w_state_nx = IDLE;
    endcase
    if (io_bus.start && (r_state != RESULT || io_bus.out_ready)) begin
      w_state_nx = COLLECT;
      w_seen_nx  = '0;
      w_tt_nx    = '0;
      w_timer_nx = '0;
      w_load     = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_seen   <= '0;
      r_tt     <= '0;
      r_timer  <= '0;
      r_op     <= '0;
      r_out_tt <= '0;
      r_match  <= 1'b0;
      r_err    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_seen  <= w_seen_nx;
      r_tt    <= w_tt_nx;
      r_timer <= w_timer_nx;
      if (w_load) begin
        r_op     <= (w_ld_err != 2'b00) ? 3'b111 : w_dec_op;
        r_out_tt <= w_ld_tt;
        r_match  <= (w_ld_err == 2'b00) && (w_dec_op != 3'b111);
        r_err    <= w_ld_err;
      end
    end
  end
  assign io_bus.in_ready  = (r_state == COLLECT);
  assign io_bus.out_valid = (r_state == RESULT);
  assign io_bus.busy      = (r_state != IDLE);
  assign io_bus.out_op    = r_op;
  assign io_bus.out_tt    = r_out_tt;
  assign io_bus.out_match = r_match;
  assign io_bus.out_err   = r_err;
endmodule

// File: tb/tb_lu_op_decoder.sv
// tb_lu_op_decoder: directed scenario tasks with hand-computed expectations for lu_op_decoder.
module tb_lu_op_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  lu_op_decoder_if bus();
  lu_op_decoder #(.TIMEOUT_CYCLES(16), .TW(5)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));
  always #5 clk = ~clk;
  logic [10:0] res;
  assign res = {bus.out_valid, bus.out_op, bus.out_tt, bus.out_match, bus.out_err};
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic go();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  task automatic samp(input logic a, input logic b, input logic s);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_s = s;
    step();
    bus.in_valid = 1'b0;
  endtask
  task automatic pop();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask
  task automatic test_reset();
    step();
    step();
    checks++;
    if ({bus.in_ready, bus.busy, res} !== 13'b0) begin
      errors++;
      $display("FAIL reset: got %b expected %b", {bus.in_ready, bus.busy, res}, 13'b0);
    end
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_functions();
    logic [3:0] tts [7];
    tts = '{4'b0011, 4'b1000, 4'b0111, 4'b0110, 4'b1001, 4'b1110, 4'b0001};
    for (int i = 0; i < 7; i++) begin
      go();
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL in_ready_after_start[%0d]: got %b expected 1", i, bus.in_ready);
      end
      for (int j = 0; j < 4; j++) begin
        if (j == 3) begin
          checks++;
          if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid[%0d]: got %b expected 0", i, bus.out_valid);
          end
        end
        samp(j[1], j[0], tts[i][j]);
      end
      checks++;
      if (res !== {1'b1, 3'(i), tts[i], 1'b1, 2'b00}) begin
        errors++;
        $display("FAIL func[%0d]: got %b expected %b", i, res, {1'b1, 3'(i), tts[i], 1'b1, 2'b00});
      end
      pop();
      checks++;
      if ({bus.out_valid, bus.busy} !== 2'b00) begin
        errors++;
        $display("FAIL func_pop[%0d]: got %b expected 00", i, {bus.out_valid, bus.busy});
      end
    end
  endtask
  task automatic test_order_dup();
    go();
    samp(1'b1, 1'b1, 1'b0);
    samp(1'b0, 1'b0, 1'b1);
    samp(1'b0, 1'b0, 1'b1);
    samp(1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL dup_early: got %b expected 0", bus.out_valid);
    end
    samp(1'b0, 1'b1, 1'b0);
    checks++;
    if (res !== 11'b1_110_0001_1_00) begin
      errors++;
      $display("FAIL dup_nor: got %b expected %b", res, 11'b1_110_0001_1_00);
    end
    pop();
  endtask
  task automatic test_nomatch();
    go();
    for (int j = 0; j < 4; j++) samp(j[1], j[0], 1'b1);
    checks++;
    if (res !== 11'b1_111_1111_0_00) begin
      errors++;
      $display("FAIL nomatch: got %b expected %b", res, 11'b1_111_1111_0_00);
    end
    pop();
  endtask
  task automatic test_timeout();
    go();
    samp(1'b0, 1'b0, 1'b1);
    samp(1'b0, 1'b1, 1'b0);
    samp(1'b1, 1'b0, 1'b1);
    repeat (12) step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %b expected 0", bus.out_valid);
    end
    step();
    checks++;
    if (res !== 11'b1_111_0101_0_10) begin
      errors++;
      $display("FAIL timeout: got %b expected %b", res, 11'b1_111_0101_0_10);
    end
    pop();
    go();
    samp(1'b0, 1'b0, 1'b0);
    samp(1'b0, 1'b1, 1'b0);
    samp(1'b1, 1'b0, 1'b0);
    repeat (12) step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_race_early: got %b expected 0", bus.out_valid);
    end
    samp(1'b1, 1'b1, 1'b1);
    checks++;
    if (res !== 11'b1_001_1000_1_00) begin
      errors++;
      $display("FAIL timeout_race: got %b expected %b", res, 11'b1_001_1000_1_00);
    end
    pop();
  endtask
  task automatic test_conflict();
    go();
    samp(1'b0, 1'b0, 1'b1);
    samp(1'b0, 1'b0, 1'b0);
`ifdef LU_DEC_CONFLICT_EN
    checks++;
    if (res !== 11'b1_111_0001_0_01) begin
      errors++;
      $display("FAIL conflict: got %b expected %b", res, 11'b1_111_0001_0_01);
    end
`else
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overwrite_early: got %b expected 0", bus.out_valid);
    end
    samp(1'b0, 1'b1, 1'b0);
    samp(1'b1, 1'b0, 1'b0);
    samp(1'b1, 1'b1, 1'b1);
    checks++;
    if (res !== 11'b1_001_1000_1_00) begin
      errors++;
      $display("FAIL overwrite: got %b expected %b", res, 11'b1_001_1000_1_00);
    end
`endif
    pop();
  endtask
  task automatic test_restart();
    go();
    samp(1'b0, 1'b0, 1'b1);
    samp(1'b0, 1'b1, 1'b1);
    bus.start = 1'b1;
    samp(1'b1, 1'b0, 1'b1);
    bus.start = 1'b0;
    samp(1'b0, 1'b0, 1'b1);
    samp(1'b0, 1'b1, 1'b1);
    samp(1'b1, 1'b1, 1'b0);
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL restart_drop: got %b expected 01", {bus.out_valid, bus.in_ready});
    end
    samp(1'b1, 1'b0, 1'b1);
    checks++;
    if (res !== 11'b1_010_0111_1_00) begin
      errors++;
      $display("FAIL restart_nand: got %b expected %b", res, 11'b1_010_0111_1_00);
    end
    pop();
  endtask
  task automatic test_hold();
    go();
    samp(1'b0, 1'b0, 1'b1);
    samp(1'b0, 1'b1, 1'b0);
    samp(1'b1, 1'b0, 1'b0);
    samp(1'b1, 1'b1, 1'b1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    checks++;
    if ({bus.in_ready, res} !== 12'b0_1_100_1001_1_00) begin
      errors++;
      $display("FAIL hold: got %b expected %b", {bus.in_ready, res}, 12'b0_1_100_1001_1_00);
    end
    pop();
  endtask
  task automatic test_back_to_back();
    go();
    samp(1'b0, 1'b0, 1'b0);
    samp(1'b0, 1'b1, 1'b1);
    samp(1'b1, 1'b0, 1'b1);
    samp(1'b1, 1'b1, 1'b1);
    checks++;
    if (res !== 11'b1_101_1110_1_00) begin
      errors++;
      $display("FAIL b2b_or: got %b expected %b", res, 11'b1_101_1110_1_00);
    end
    bus.start = 1'b1;
    pop();
    bus.start = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b011) begin
      errors++;
      $display("FAIL b2b_restart: got %b expected 011", {bus.out_valid, bus.in_ready, bus.busy});
    end
    samp(1'b0, 1'b0, 1'b0);
    samp(1'b0, 1'b1, 1'b1);
    samp(1'b1, 1'b0, 1'b1);
    samp(1'b1, 1'b1, 1'b0);
    checks++;
    if (res !== 11'b1_011_0110_1_00) begin
      errors++;
      $display("FAIL b2b_xor: got %b expected %b", res, 11'b1_011_0110_1_00);
    end
  endtask
  task automatic test_async_reset();
    go();
    samp(1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.busy, res} !== 13'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", {bus.in_ready, bus.busy, res}, 13'b0);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({bus.busy, bus.out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL after_reset: got %b expected 00", {bus.busy, bus.out_valid});
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = 1'b0;
    bus.in_b = 1'b0;
    bus.in_s = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_functions();
    test_order_dup();
    test_nomatch();
    test_timeout();
    test_conflict();
    test_restart();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lu_op_decoder.md
# lu_op_decoder

Recovers the 3-bit operation select of the gate-level logic unit (NOT A, AND, NAND, XOR, XNOR, OR, NOR) from observed operand/result samples. It sits on the observation side of the logic unit. It collects one result per operand pair (a,b) over a valid/ready stream, builds the 4-entry truth table and decodes it back to the select code. The result, with match and error flags, is presented on a valid/ready output port.

## Interface
- TIMEOUT_CYCLES, 16: maximum cycles allowed in COLLECT before abort; 0 disables the timeout.
- TW, 5: width of the timeout counter; must satisfy 2^TW > TIMEOUT_CYCLES.

- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a new decode.
- in_valid  input  1  sample valid.
- in_ready  output  1  high only in COLLECT.
- in_a  input  1  sample operand a.
- in_b  input  1  sample operand b.
- in_s  input  1  logic-unit result for (in_a, in_b).
- out_valid  output  1  result valid; high only in RESULT.
- out_ready  input  1  result consumed.
- out_op  output  3  decoded select: 000 NOT A, 001 AND, 010 NAND, 011 XOR, 100 XNOR, 101 OR, 110 NOR, 111 no match.
- out_tt  output  4  captured truth table; bit index = {a,b}.
- out_match  output  1  1 when out_tt equals one of the seven known functions.
- out_err  output  2  00 none, 01 conflict, 10 timeout.
- busy  output  1  high in COLLECT or RESULT.

## Operation
- States: IDLE, COLLECT, RESULT.
- IDLE -> COLLECT on start; clears the seen mask, tt and timer.
- COLLECT:
  - A sample is accepted on in_valid & in_ready.
  - An accept sets seen[{a,b}] and writes tt[{a,b}] = in_s.
  - A repeat of an already-seen pair with the same in_s is ignored.
- COLLECT -> RESULT at the accepting edge when the seen mask becomes 1111. Outputs load at that same edge.
- Decode table, out_tt -> out_op:
  - 0011 -> 000 (NOT A); 1000 -> 001 (AND); 0111 -> 010 (NAND); 0110 -> 011 (XOR).
  - 1001 -> 100 (XNOR); 1110 -> 101 (OR); 0001 -> 110 (NOR).
  - Any other value -> 111 with out_match=0.
- Timeout: timer counts cycles spent in COLLECT. At timer == TIMEOUT_CYCLES-1 without completion -> RESULT, out_err=10, out_op=111, out_match=0, out_tt = partial table.
- RESULT -> IDLE on out_valid & out_ready. If start is also high that cycle -> COLLECT directly.
- start during COLLECT restarts: mask, tt and timer are cleared; any sample on the same edge is dropped.
- start during RESULT without out_ready is ignored.
- Outputs hold stable throughout RESULT.

## Timing
- Reset values: state IDLE, in_ready=0, out_valid=0, out_op=000, out_tt=0000, out_match=0, out_err=00, busy=0.
- Reset asserted mid-decode aborts immediately. No result is produced.
- in_ready rises the cycle after the start edge.
- Minimum decode: start edge, then 4 accepting edges. out_valid is high after the 4th accept edge, so 5 edges from start.
- Completion and timeout on the same edge: completion wins, out_err=00.
- Conflict and completion on the same edge: conflict wins.
- out_valid high with out_ready high gives a one-cycle result; back-to-back decodes need start on that edge.

## Configuration
- LU_DEC_CONFLICT_EN defined:
  - A sample for an already-seen pair with a differing in_s moves the block to RESULT at that edge.
  - That result carries out_err=01, out_op=111, out_match=0 and out_tt as stored before the conflicting sample.
- LU_DEC_CONFLICT_EN undefined: the later sample overwrites tt[{a,b}] and collection continues; out_err=01 never occurs.

## Test plan
- Start, then samples (0,0,0), (0,1,0), (1,0,0), (1,1,1) -> out_valid, out_tt=1000, out_op=001, out_match=1, out_err=00. Repeat for all seven functions, each returning its select code.
- Samples in order (1,1), (0,0), (1,0), (0,1) with NOR results, plus a duplicate (0,0,1) in between -> out_tt=0001, out_op=110.
- Samples yielding tt=1111 -> out_op=111, out_match=0, out_err=00.
- TIMEOUT_CYCLES=16, only 3 samples -> RESULT 16 cycles after entering COLLECT, out_err=10; a 4th sample arriving on that same edge -> normal result instead.
- With LU_DEC_CONFLICT_EN: (0,0,1) then (0,0,0) -> out_err=01. Without the macro: decode continues using in_s=0.
- rst_n low mid-COLLECT -> all outputs at reset values asynchronously. start during RESULT with out_ready=0 -> outputs held.
